alu_ctrl_seq: RTL and testbench

Queued, multi-cycle control sequencer for the 8-bit Power ALU. Accepts opcodes over a valid/ready handshake into a parametrised FIFO, then issues each one through an EXEC/WB state machine. It drives the compare, and/or/not, add/sub, output-mux and accumulator control lines for a programmable number of cycles per operation. Unused control fields return to their no-op defaults, and the accumulator write is an explicit per-operation pulse.

---
 rtl/alu_ctrl_seq_if.sv | 11 +
 rtl/alu_ctrl_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
// Opcode handshake bundle for alu_ctrl_seq.
// The master offers {acc_wr, opcode} with op_valid; the slave accepts with op_ready.
interface alu_ctrl_seq_if;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] opcode;
  logic       acc_wr;

  modport master (output op_valid, output opcode, output acc_wr, input op_ready);
  modport slave  (input op_valid, input opcode, input acc_wr, output op_ready);
endinterface

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: queued control sequencer for the 8-bit Power ALU.
// Opcodes are queued in a DEPTH-entry FIFO and issued through IDLE -> EXEC -> WB.
// EXEC holds the decoded ALU controls for EXEC_CYCLES cycles. WB holds them for one
// more cycle, pulses done and strobes the accumulator if the op asked for it.
// Optional feature: define ALU_CTRL_BYPASS_EN to let an op that arrives while the
// sequencer is idle and the queue is empty skip the FIFO and enter EXEC one edge earlier.
module alu_ctrl_seq #(
  parameter int DEPTH       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_ctrl_seq_if.slave              op_if,
  output logic [3:0]                 compare_ctrl,
  output logic [1:0]                 andornot_ctrl,
  output logic                       addsub_ctrl,
  output logic [1:0]                 mux_ctrl,
  output logic                       accumulator_ctrl,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CYC_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  // Packed control word {compare[3:0], andornot[1:0], addsub, mux[1:0]} with no-op defaults
  localparam logic [8:0] CTRL_IDLE = {4'b0000, 2'b11, 1'b0, 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  // Map an opcode onto its control field; every other field stays at its default
  function automatic logic [8:0] f_decode(input logic [3:0] op);
    logic [8:0] v;
    v = CTRL_IDLE;
    case (op)
      4'b0000: v[8:5] = 4'b0010;
      4'b0001: v[8:5] = 4'b0011;
      4'b0100: v[8:5] = 4'b0100;
      4'b0101: v[8:5] = 4'b0101;
      4'b1001: v[8:5] = 4'b0110;
      4'b1010: v[8:5] = 4'b0111;
      4'b1011: v[8:5] = 4'b1100;
      4'b1100: v[8:5] = 4'b1101;
      4'b1101: v[8:5] = 4'b1110;
      4'b1110: v[8:5] = 4'b1111;
      4'b0010: v[1:0] = 2'b10;
      4'b0011: begin v[2] = 1'b1; v[1:0] = 2'b10; end
      4'b0110: begin v[4:3] = 2'b00; v[1:0] = 2'b01; end
      4'b0111: begin v[4:3] = 2'b11; v[1:0] = 2'b01; end
      4'b1000: begin v[4:3] = 2'b01; v[1:0] = 2'b01; end
      4'b1111: begin v[4:3] = 2'b10; v[1:0] = 2'b01; end
      default: ;
    endcase
    return v;
  endfunction

  logic [4:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_op_ready;
  state_t           r_state;
  logic [CYC_W-1:0] r_cnt;
  logic [3:0]       r_op;
  logic             r_acc;
  logic [8:0]       r_ctrl;
  logic             r_accum, r_busy, r_done;

  state_t           w_state_next;
  logic [CYC_W-1:0] w_cnt_next;
  logic [3:0]       w_op_next;
  logic             w_acc_next;
  logic [8:0]       w_ctrl_next;
  logic             w_accum_next, w_done_next;
  logic             w_push, w_wr, w_pop, w_bypass;
  logic [4:0]       w_head;
  logic [CNT_W-1:0] w_count_next;

  assign w_push = op_if.op_valid && r_op_ready;
  assign w_wr   = w_push && !w_bypass;
  assign w_head = r_mem[r_rd_ptr];

  // Next-state, issue and registered-output decode for the sequencer
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_op_next    = r_op;
    w_acc_next   = r_acc;
    w_pop        = 1'b0;
    w_bypass     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_op_next    = w_head[3:0];
          w_acc_next   = w_head[4];
          w_cnt_next   = '0;
          w_state_next = S_EXEC;
        end
`ifdef ALU_CTRL_BYPASS_EN
        else if (w_push) begin
          w_bypass     = 1'b1;
          w_op_next    = op_if.opcode;
          w_acc_next   = op_if.acc_wr;
          w_cnt_next   = '0;
          w_state_next = S_EXEC;
        end
`endif
      end
      S_EXEC: begin
        if (r_cnt == CYC_W'(EXEC_CYCLES - 1)) begin
          w_cnt_next   = '0;
          w_state_next = S_WB;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_WB: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_op_next    = w_head[3:0];
          w_acc_next   = w_head[4];
          w_cnt_next   = '0;
          w_state_next = S_EXEC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_ctrl_next  = CTRL_IDLE;
    w_accum_next = 1'b0;
    w_done_next  = 1'b0;
    case (w_state_next)
      S_EXEC: w_ctrl_next = f_decode(w_op_next);
      S_WB: begin
        w_ctrl_next  = f_decode(w_op_next);
        w_accum_next = w_acc_next;
        w_done_next  = 1'b1;
      end
      default: ;
    endcase
  end

  // Occupancy after this edge's push and pop
  always_comb begin
    w_count_next = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: ;
    endcase
  end

  // FIFO storage; no reset needed since only entries below the count are read
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {op_if.acc_wr, op_if.opcode};
  end

  // FIFO pointers, count and registered ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_op_ready <= 1'b1;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_next;
      r_op_ready <= (w_count_next < CNT_W'(DEPTH));
    end
  end

  // Sequencer state and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_acc   <= 1'b0;
      r_ctrl  <= CTRL_IDLE;
      r_accum <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_op    <= w_op_next;
      r_acc   <= w_acc_next;
      r_ctrl  <= w_ctrl_next;
      r_accum <= w_accum_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_done_next;
    end
  end

  assign op_if.op_ready   = r_op_ready;
  assign compare_ctrl     = r_ctrl[8:5];
  assign andornot_ctrl    = r_ctrl[4:3];
  assign addsub_ctrl      = r_ctrl[2];
  assign mux_ctrl         = r_ctrl[1:0];
  assign accumulator_ctrl = r_accum;
  assign busy             = r_busy;
  assign done             = r_done;
  assign fifo_count       = r_count;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq (DEPTH=4, EXEC_CYCLES=2).
// A queue-and-countdown model predicts every output each cycle; directed
// literal checks pin latency, back-to-back issue, full-FIFO and reset behaviour.
module tb_alu_ctrl_seq;
  localparam int DEPTH = 4;
  localparam int EXEC  = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] compare_ctrl;
  logic [1:0] andornot_ctrl;
  logic       addsub_ctrl;
  logic [1:0] mux_ctrl;
  logic       accumulator_ctrl;
  logic       busy;
  logic       done;
  logic [2:0] fifo_count;

  alu_ctrl_seq_if bus ();

  alu_ctrl_seq #(.DEPTH(DEPTH), .EXEC_CYCLES(EXEC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .op_if            (bus),
    .compare_ctrl     (compare_ctrl),
    .andornot_ctrl    (andornot_ctrl),
    .addsub_ctrl      (addsub_ctrl),
    .mux_ctrl         (mux_ctrl),
    .accumulator_ctrl (accumulator_ctrl),
    .busy             (busy),
    .done             (done),
    .fifo_count       (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  bit chk_en = 0;

  // Model: queued ops plus cycles remaining for the op in flight (0 = idle, 1 = WB)
  logic [4:0] mq[$];
  int         rem = 0;
  logic [4:0] cur = '0;

  // Spec decode table as {compare, andornot, addsub, mux}
  function automatic logic [8:0] ref_decode(input logic [3:0] op);
    case (op)
      4'h0: return {4'b0010, 2'b11, 1'b0, 2'b00};
      4'h1: return {4'b0011, 2'b11, 1'b0, 2'b00};
      4'h4: return {4'b0100, 2'b11, 1'b0, 2'b00};
      4'h5: return {4'b0101, 2'b11, 1'b0, 2'b00};
      4'h9: return {4'b0110, 2'b11, 1'b0, 2'b00};
      4'hA: return {4'b0111, 2'b11, 1'b0, 2'b00};
      4'hB: return {4'b1100, 2'b11, 1'b0, 2'b00};
      4'hC: return {4'b1101, 2'b11, 1'b0, 2'b00};
      4'hD: return {4'b1110, 2'b11, 1'b0, 2'b00};
      4'hE: return {4'b1111, 2'b11, 1'b0, 2'b00};
      4'h2: return {4'b0000, 2'b11, 1'b0, 2'b10};
      4'h3: return {4'b0000, 2'b11, 1'b1, 2'b10};
      4'h6: return {4'b0000, 2'b00, 1'b0, 2'b01};
      4'h7: return {4'b0000, 2'b11, 1'b0, 2'b01};
      4'h8: return {4'b0000, 2'b01, 1'b0, 2'b01};
      default: return {4'b0000, 2'b10, 1'b0, 2'b01};
    endcase
  endfunction

  function automatic logic [15:0] model_vec();
    logic [8:0] d;
    d = (rem == 0) ? {4'b0000, 2'b11, 1'b0, 2'b00} : ref_decode(cur[3:0]);
    return {mq.size() < DEPTH, d, (rem == 1) && cur[4], rem != 0, rem == 1, 3'(mq.size())};
  endfunction

  wire [15:0] dut_vec = {bus.op_ready, compare_ctrl, andornot_ctrl, addsub_ctrl, mux_ctrl,
                         accumulator_ctrl, busy, done, fifo_count};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc_ok;
    int pre_rem;
    bit pre_empty;
    acc_ok    = bus.op_valid && (mq.size() < DEPTH);
    pre_rem   = rem;
    pre_empty = (mq.size() == 0);
    if ((rem == 0 || rem == 1) && !pre_empty) begin
      cur = mq.pop_front();
      rem = EXEC + 1;
    end else if (rem > 0) begin
      rem--;
    end
    if (acc_ok) begin
`ifdef ALU_CTRL_BYPASS_EN
      if (pre_rem == 0 && pre_empty) begin
        cur = {bus.acc_wr, bus.opcode};
        rem = EXEC + 1;
      end else
`endif
      mq.push_back({bus.acc_wr, bus.opcode});
    end
  endtask

  // Model advance on every edge; asynchronous reset empties it
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        rem = 0;
      end else begin
        model_step();
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cycle", dut_vec, model_vec());
        if (done) done_seen++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || fifo_count != 0) && n < 300);
    check("idle_wait", 16'({busy, fifo_count != 0}), 16'd0);
  endtask

  initial begin
    int n;
    int d0;
    bus.op_valid = 1'b0;
    bus.opcode   = '0;
    bus.acc_wr   = 1'b0;
    #2 rst_n = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready", 16'(bus.op_ready), 16'd1);
    check("rst_count", 16'(fifo_count), 16'd0);
    check("rst_busy_done", 16'({busy, done, accumulator_ctrl}), 16'd0);
    check("rst_ctrl", 16'({compare_ctrl, andornot_ctrl, addsub_ctrl, mux_ctrl}), 16'b0000_11_0_00);

    // Sub with accumulator write: 2 EXEC cycles, WB, then idle
    tick();
    bus.op_valid = 1'b1; bus.opcode = 4'b0011; bus.acc_wr = 1'b1;
    tick();
    bus.op_valid = 1'b0;
`ifndef ALU_CTRL_BYPASS_EN
    tick();
`endif
    @(negedge clk);
    check("A_exec1", 16'({mux_ctrl, addsub_ctrl, busy, done, accumulator_ctrl}), 16'b10_1_1_0_0);
    tick(); @(negedge clk);
    check("A_exec2", 16'({mux_ctrl, addsub_ctrl, busy, done, accumulator_ctrl}), 16'b10_1_1_0_0);
    tick(); @(negedge clk);
    check("A_wb", 16'({mux_ctrl, addsub_ctrl, busy, done, accumulator_ctrl}), 16'b10_1_1_1_1);
    tick(); @(negedge clk);
    check("A_idle", 16'({mux_ctrl, addsub_ctrl, busy, done, accumulator_ctrl}), 16'd0);

    // Back-to-back logic then compare op, no idle gap
    tick();
    bus.op_valid = 1'b1; bus.opcode = 4'b0110; bus.acc_wr = 1'b0;
    tick();
    bus.opcode = 4'b1011;
    tick();
    bus.op_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 20);
    check("B_wait_done", 16'(done), 16'd1);
    check("B_op1", 16'({andornot_ctrl, mux_ctrl}), 16'b00_01);
    @(negedge clk);
    check("B_op2", 16'({compare_ctrl, mux_ctrl, andornot_ctrl, busy}), 16'b1100_00_11_1);
    wait_idle();

    // Hold op_valid until the FIFO fills; a pop while full does not accept
    tick();
    bus.op_valid = 1'b1;
    n = 0;
    do begin
      bus.opcode = 4'($urandom); bus.acc_wr = 1'($urandom);
      tick();
      n++;
    end while (bus.op_ready && n < 20);
    @(negedge clk);
    check("C_full_count", 16'(fifo_count), 16'd4);
    check("C_full_ready", 16'(bus.op_ready), 16'd0);
    n = 0;
    while (fifo_count == 3'd4 && n < 10) begin @(negedge clk); n++; end
    check("C_after_pop", 16'(fifo_count), 16'd3);
    tick();
    bus.op_valid = 1'b0;
    wait_idle();

    // All 16 opcodes, each once
    d0 = done_seen;
    tick();
    for (int i = 0; i < 16; i++) begin
      bus.op_valid = 1'b1; bus.opcode = 4'(i); bus.acc_wr = 1'($urandom);
      n = 0;
      while (!bus.op_ready && n < 50) begin tick(); n++; end
      tick();
    end
    bus.op_valid = 1'b0;
    wait_idle();
    check("D_done_count", 16'(done_seen - d0), 16'd16);

    // Random traffic
    tick();
    for (int i = 0; i < 400; i++) begin
      bus.op_valid = ($urandom_range(0, 3) != 0);
      bus.opcode   = 4'($urandom);
      bus.acc_wr   = 1'($urandom);
      tick();
    end
    bus.op_valid = 1'b0;
    wait_idle();

    // Reset in the middle of EXEC with acc_wr set
    tick();
    bus.op_valid = 1'b1; bus.opcode = 4'b0010; bus.acc_wr = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(busy && !done) && n < 20);
    check("F_in_exec", 16'({busy, done}), 16'b10);
    #2 rst_n = 1'b0;
    #1;
    check("F_rst_ctrl", 16'({compare_ctrl, andornot_ctrl, addsub_ctrl, mux_ctrl}), 16'b0000_11_0_00);
    check("F_rst_flags", 16'({busy, done, accumulator_ctrl, fifo_count}), 16'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("F_after", 16'({busy, done, accumulator_ctrl}), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
